// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array control path: pass-tracking
// state encoding and default array geometry used by the array controller
// and the activation window tracker.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    ACTIVE = 2'd2
  } act_state_t;

  localparam int DEFAULT_ARRAY_DIM  = 16;
  localparam int DEFAULT_MAX_INPUTS = 64;

endpackage

// File: rtl/activation_window_ctrl.sv
// Tracks one systolic-array pass: a fill window of ARRAY_DIM non-stalled
// cycles, then an active window of N non-stalled cycles where the array
// outputs are valid. Provides a per-beat row index, a done pulse and a
// one-deep pending trigger so passes can run back to back.
module activation_window_ctrl
  import systolic_pkg::*;
#(
  parameter int ARRAY_DIM  = DEFAULT_ARRAY_DIM,
  parameter int MAX_INPUTS = DEFAULT_MAX_INPUTS,
  localparam int NI_W  = $clog2(MAX_INPUTS + 1),
  localparam int IX_W  = (MAX_INPUTS > 1) ? $clog2(MAX_INPUTS) : 1,
  localparam int CNT_W = $clog2(((ARRAY_DIM > MAX_INPUTS) ? ARRAY_DIM : MAX_INPUTS) + 1)
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            trigger_array,
  input  logic [NI_W-1:0] num_inputs,
  input  logic            stall,
  output logic            activated,
  output logic [IX_W-1:0] out_index,
  output logic            busy,
  output logic            done,
  output logic            trig_drop
);

  localparam logic [NI_W-1:0]  N_MAX     = NI_W'(MAX_INPUTS);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(ARRAY_DIM - 1);

  act_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [NI_W-1:0]  n_cur;
  logic             pend_valid;
  logic [NI_W-1:0]  pend_n;

  logic [NI_W-1:0]  n_req;
  logic [CNT_W-1:0] active_last;
  logic             fill_end;
  logic             final_beat;

  // Clamp the requested count and decode the window terminal conditions.
  always_comb begin
    n_req       = (num_inputs > N_MAX) ? N_MAX : num_inputs;
    active_last = CNT_W'(n_cur) - CNT_W'(1);
    fill_end    = (state == FILL) && !stall && (cnt == FILL_LAST);
    final_beat  = (state == ACTIVE) && !stall && (cnt == active_last);
  end

  // Output decode: a beat is valid only in ACTIVE and only when not stalled;
  // the row index holds its value across stalls.
  always_comb begin
    activated = (state == ACTIVE) && !stall;
    out_index = (state == ACTIVE) ? cnt[IX_W-1:0] : '0;
    busy      = (state != IDLE);
  end

  // Pass sequencer: window counting, pass chaining and the pending slot.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      n_cur      <= '0;
      pend_valid <= 1'b0;
      pend_n     <= '0;
      done       <= 1'b0;
      trig_drop  <= 1'b0;
    end else begin
      done      <= 1'b0;
      trig_drop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pend_valid) begin
            // A zero-length pending pass left over from a chained finish.
            pend_valid <= trigger_array;
            if (trigger_array) pend_n <= n_req;
            if (pend_n == '0) begin
              done <= 1'b1;
            end else begin
              n_cur <= pend_n;
              cnt   <= '0;
              state <= FILL;
            end
          end else if (trigger_array) begin
            if (n_req == '0) begin
              done <= 1'b1;
            end else begin
              n_cur <= n_req;
              cnt   <= '0;
              state <= FILL;
            end
          end
        end

        FILL: begin
          if (fill_end) begin
            cnt   <= '0;
            state <= ACTIVE;
          end else if (!stall) begin
            cnt <= cnt + CNT_W'(1);
          end
          if (trigger_array) begin
            if (!pend_valid) begin
              pend_valid <= 1'b1;
              pend_n     <= n_req;
            end else begin
              trig_drop <= 1'b1;
            end
          end
        end

        ACTIVE: begin
          if (final_beat) begin
            done <= 1'b1;
            cnt  <= '0;
            if (pend_valid && (pend_n != '0)) begin
              n_cur      <= pend_n;
              state      <= FILL;
              pend_valid <= trigger_array;
              if (trigger_array) pend_n <= n_req;
            end else if (pend_valid) begin
              // Zero-length pending pass: IDLE services it next cycle.
              state <= IDLE;
              if (trigger_array) trig_drop <= 1'b1;
            end else if (trigger_array && (n_req != '0)) begin
              n_cur <= n_req;
              state <= FILL;
            end else begin
              state <= IDLE;
              if (trigger_array) begin
                pend_valid <= 1'b1;
                pend_n     <= '0;
              end
            end
          end else begin
            if (!stall) cnt <= cnt + CNT_W'(1);
            if (trigger_array) begin
              if (!pend_valid) begin
                pend_valid <= 1'b1;
                pend_n     <= n_req;
              end else begin
                trig_drop <= 1'b1;
              end
            end
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_activation_window_ctrl.sv
// Self-checking bench for activation_window_ctrl with ARRAY_DIM=16 and
// MAX_INPUTS=64. Cycle k runs from just after one rising edge to the next;
// inputs driven in cycle k are sampled at its closing edge, and outputs are
// checked at the falling edge inside cycle k.
module tb_activation_window_ctrl;

  localparam int NI_W = 7;
  localparam int IX_W = 6;

  logic            clk;
  logic            n_rst;
  logic            trigger_array;
  logic [NI_W-1:0] num_inputs;
  logic            stall;
  logic            activated;
  logic [IX_W-1:0] out_index;
  logic            busy;
  logic            done;
  logic            trig_drop;

  int checks = 0;
  int errors = 0;

  activation_window_ctrl #(
    .ARRAY_DIM (16),
    .MAX_INPUTS(64)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .trigger_array(trigger_array),
    .num_inputs   (num_inputs),
    .stall        (stall),
    .activated    (activated),
    .out_index    (out_index),
    .busy         (busy),
    .done         (done),
    .trig_drop    (trig_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One table row describes a whole scenario as per-cycle bit masks
  // (bit k = value in cycle k) plus a window of expected row indices.
  typedef struct packed {
    int              len;
    logic [63:0]     trig;
    logic [63:0]     stl;
    logic [63:0]     act;
    logic [63:0]     bsy;
    logic [63:0]     dne;
    logic [63:0]     drp;
    int              n_first;
    int              n_rest;
    int              idx_start;
    int              idx_len;
    logic [7:0][5:0] idx_exp;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] one(input int c);
    return rng(c, c);
  endfunction

  // Starts a new cycle: drive inputs just after the rising edge, then move
  // to the falling edge where outputs are checked.
  task automatic applyStimulus(input logic trig, input int n, input logic stl);
    @(posedge clk);
    #1;
    trigger_array = trig;
    num_inputs    = NI_W'(n);
    stall         = stl;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int scen, input int cyc,
                             input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s scen %0d cycle %0d: got %0d expected %0d",
               name, scen, cyc, actual, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag, input int scen);
    checkOutput({tag, "_activated"}, scen, -1, int'(activated), 0);
    checkOutput({tag, "_busy"},      scen, -1, int'(busy),      0);
    checkOutput({tag, "_done"},      scen, -1, int'(done),      0);
    checkOutput({tag, "_out_index"}, scen, -1, int'(out_index), 0);
    checkOutput({tag, "_trig_drop"}, scen, -1, int'(trig_drop), 0);
  endtask

  task automatic doReset(input int scen);
    n_rst         = 1'b0;
    trigger_array = 1'b0;
    num_inputs    = '0;
    stall         = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset", scen);
    n_rst = 1'b1;
  endtask

  initial begin
    int   beats;
    logic first;
    logic trig;
    int   n;
    int   k_idx;

    n_rst         = 1'b0;
    trigger_array = 1'b0;
    num_inputs    = '0;
    stall         = 1'b0;

    for (int i = 0; i < 5; i++) vecs[i] = '0;

    // Single pass, N=4, no stall.
    vecs[0].len = 24; vecs[0].trig = one(0); vecs[0].n_first = 4; vecs[0].n_rest = 4;
    vecs[0].act = rng(17, 20); vecs[0].bsy = rng(1, 20); vecs[0].dne = one(21);
    vecs[0].idx_start = 17; vecs[0].idx_len = 4;
    vecs[0].idx_exp[0] = 6'd0; vecs[0].idx_exp[1] = 6'd1;
    vecs[0].idx_exp[2] = 6'd2; vecs[0].idx_exp[3] = 6'd3;

    // Stall in FILL, cycles 5..7.
    vecs[1].len = 27; vecs[1].trig = one(0); vecs[1].n_first = 4; vecs[1].n_rest = 4;
    vecs[1].stl = rng(5, 7);
    vecs[1].act = rng(20, 23); vecs[1].bsy = rng(1, 23); vecs[1].dne = one(24);
    vecs[1].idx_start = 20; vecs[1].idx_len = 4;
    vecs[1].idx_exp[0] = 6'd0; vecs[1].idx_exp[1] = 6'd1;
    vecs[1].idx_exp[2] = 6'd2; vecs[1].idx_exp[3] = 6'd3;

    // Stall in ACTIVE at cycle 18; index held at 1.
    vecs[2].len = 25; vecs[2].trig = one(0); vecs[2].n_first = 4; vecs[2].n_rest = 4;
    vecs[2].stl = one(18);
    vecs[2].act = one(17) | rng(19, 21); vecs[2].bsy = rng(1, 21); vecs[2].dne = one(22);
    vecs[2].idx_start = 17; vecs[2].idx_len = 5;
    vecs[2].idx_exp[0] = 6'd0; vecs[2].idx_exp[1] = 6'd1; vecs[2].idx_exp[2] = 6'd1;
    vecs[2].idx_exp[3] = 6'd2; vecs[2].idx_exp[4] = 6'd3;

    // Back-to-back via the pending slot: N=4 at 0, N=2 at 5.
    vecs[3].len = 42; vecs[3].trig = one(0) | one(5); vecs[3].n_first = 4; vecs[3].n_rest = 2;
    vecs[3].act = rng(17, 20) | rng(37, 38); vecs[3].bsy = rng(1, 38);
    vecs[3].dne = one(21) | one(39);
    vecs[3].idx_start = 37; vecs[3].idx_len = 2;
    vecs[3].idx_exp[0] = 6'd0; vecs[3].idx_exp[1] = 6'd1;

    // Overflow: triggers at 0, 3, 4 with N=1; the third is dropped.
    vecs[4].len = 38; vecs[4].trig = one(0) | one(3) | one(4); vecs[4].n_first = 1; vecs[4].n_rest = 1;
    vecs[4].act = one(17) | one(34); vecs[4].bsy = rng(1, 34);
    vecs[4].dne = one(18) | one(35); vecs[4].drp = one(5);
    vecs[4].idx_start = 34; vecs[4].idx_len = 1;
    vecs[4].idx_exp[0] = 6'd0;

    for (int v = 0; v < 5; v++) begin
      doReset(v);
      first = 1'b1;
      for (int k = 0; k < vecs[v].len; k++) begin
        trig = vecs[v].trig[k];
        n    = first ? vecs[v].n_first : vecs[v].n_rest;
        if (trig) first = 1'b0;
        applyStimulus(trig, n, vecs[v].stl[k]);
        checkOutput("activated", v, k, int'(activated), int'(vecs[v].act[k]));
        checkOutput("busy",      v, k, int'(busy),      int'(vecs[v].bsy[k]));
        checkOutput("done",      v, k, int'(done),      int'(vecs[v].dne[k]));
        checkOutput("trig_drop", v, k, int'(trig_drop), int'(vecs[v].drp[k]));
        k_idx = k - vecs[v].idx_start;
        if (k_idx >= 0 && k_idx < vecs[v].idx_len)
          checkOutput("out_index", v, k, int'(out_index), int'(vecs[v].idx_exp[k_idx]));
      end
    end

    // Same-cycle restart: N=1 at 0, then N=3 on its final beat (cycle 17).
    doReset(5);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(k == 0 || k == 17, (k == 0) ? 1 : 3, 1'b0);
      checkOutput("activated", 5, k, int'(activated), int'(k == 17 || (k >= 34 && k <= 36)));
      checkOutput("busy",      5, k, int'(busy),      int'(k >= 1 && k <= 36));
      checkOutput("done",      5, k, int'(done),      int'(k == 18 || k == 37));
      if (k >= 34 && k <= 36) checkOutput("out_index", 5, k, int'(out_index), k - 34);
    end

    // Asynchronous reset in the middle of the active window.
    doReset(6);
    for (int k = 0; k <= 18; k++) applyStimulus(k == 0, 4, 1'b0);
    checkOutput("pre_reset_activated", 6, 18, int'(activated), 1);
    checkOutput("pre_reset_out_index", 6, 18, int'(out_index), 1);
    n_rst = 1'b0;
    #1;
    checkIdleOutputs("midpass_reset", 6);
    trigger_array = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("held_reset", 6);
    n_rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(k == 0, 1, 1'b0);
      checkOutput("post_reset_activated", 6, k, int'(activated), int'(k == 17));
      checkOutput("post_reset_done",      6, k, int'(done),      int'(k == 18));
    end

    // Zero-length request: done only.
    doReset(7);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(k == 0, 0, 1'b0);
      checkOutput("n0_activated", 7, k, int'(activated), 0);
      checkOutput("n0_busy",      7, k, int'(busy),      0);
      checkOutput("n0_done",      7, k, int'(done),      int'(k == 1));
    end

    // Oversized request is clamped to 64 beats.
    doReset(8);
    beats = 0;
    for (int k = 0; k < 85; k++) begin
      applyStimulus(k == 0, 100, 1'b0);
      if (activated) beats++;
      checkOutput("clamp_done", 8, k, int'(done), int'(k == 81));
      if (k == 80) checkOutput("clamp_last_index", 8, k, int'(out_index), 63);
      if (k == 82) checkOutput("clamp_busy_after", 8, k, int'(busy), 0);
    end
    checkOutput("clamp_beats", 8, 85, beats, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
